data_sram_responder: RTL and testbench

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_responder_pkg.sv | 19 +
 rtl/data_sram_responder_sram_wait_timer.sv | 48 ++++
 rtl/data_sram_responder.sv | 147 ++++++++++++++
 tb/tb_data_sram_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// data_sram_responder_pkg : FSM encodings and default geometry for the
//                           data-side SRAM responder.  Rev 1.0
// ============================================================================
package data_sram_responder_pkg;

    localparam int unsigned c_DEF_WAIT_CYCLES = 2;
    localparam int unsigned c_DEF_ADDR_W      = 16;
    localparam int unsigned c_CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/data_sram_responder_sram_wait_timer.sv
`default_nettype none
// ============================================================================
// sram_wait_timer : reloadable wait down-counter with look-ahead expiry flag.
//                   Rev 1.0
// ============================================================================
module sram_wait_timer
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);

    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(LOAD_VAL);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = c_LOAD;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Expiry looks at the value being loaded, so the FSM can move to GRANT
    // on the same edge that the count reaches zero.
    assign expire_o = (cnt_d == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// data_sram_responder : CPU data-port to synchronous single-port RAM bridge
//                       with programmable wait-state insertion.  Rev 1.0
// ============================================================================
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = c_DEF_WAIT_CYCLES,
    parameter int unsigned ADDR_W      = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sram_en,
    input  logic [3:0]        sram_wen,
    input  logic [31:0]       sram_addr,
    input  logic [31:0]       sram_wdata,
    output logic [31:0]       sram_rdata,
    output logic              mem_available,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       stall_cnt
);

    localparam logic        c_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam int unsigned c_LOAD      = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

    state_e              state_q, state_d;
    logic [3:0]          lat_wen_q, lat_wen_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic                rd_pend_q, rd_pend_d;
    logic [31:0]         hold_q, hold_d;
    logic [31:0]         stall_q, stall_d;

    logic                w_tmr_clr;
    logic                w_tmr_load;
    logic                w_tmr_dec;
    logic                w_tmr_expire;
    logic                w_grant_fsm;
    logic                w_grant;
    logic                w_req_changed;
    logic [ADDR_W-1:0]   w_word_addr;
    logic                w_unused_addr;

    assign w_word_addr   = sram_addr[ADDR_W+1:2];
    assign w_unused_addr = ^{sram_addr[31:ADDR_W+2], sram_addr[1:0]};
    assign w_req_changed = (sram_wen != lat_wen_q) || (w_word_addr != lat_addr_q);

    sram_wait_timer #(
        .LOAD_VAL (c_LOAD)
    ) u_wait_timer (
        .clk      (clk),
        .resetn   (resetn),
        .clr_i    (w_tmr_clr),
        .load_i   (w_tmr_load),
        .dec_i    (w_tmr_dec),
        .expire_o (w_tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        lat_wen_d   = lat_wen_q;
        lat_addr_d  = lat_addr_q;
        w_tmr_clr   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        w_grant_fsm = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sram_en) begin
                    if (c_ZERO_WAIT) begin
                        w_grant_fsm = 1'b1;
                    end else begin
                        w_tmr_load = 1'b1;
                        lat_wen_d  = sram_wen;
                        lat_addr_d = w_word_addr;
                        state_d    = w_tmr_expire ? ST_GRANT : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!sram_en) begin
                    w_tmr_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (w_req_changed) begin
                    // A different request is treated as brand new.
                    w_tmr_load = 1'b1;
                    lat_wen_d  = sram_wen;
                    lat_addr_d = w_word_addr;
                    state_d    = w_tmr_expire ? ST_GRANT : ST_WAIT;
                end else begin
                    w_tmr_dec = 1'b1;
                    state_d   = w_tmr_expire ? ST_GRANT : ST_WAIT;
                end
            end
            ST_GRANT: begin
                w_grant_fsm = sram_en;
                w_tmr_clr   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                w_tmr_clr = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Reset must block the zero-wait combinational grant path as well.
    assign w_grant       = w_grant_fsm & resetn;
    assign mem_available = ~resetn | ~sram_en | w_grant;

    assign ram_en    = w_grant;
    assign ram_we    = w_grant ? sram_wen : 4'b0000;
    assign ram_addr  = w_word_addr;
    assign ram_wdata = sram_wdata;

    assign rd_pend_d = w_grant && (sram_wen == 4'b0000);
    assign hold_d    = rd_pend_q ? ram_rdata : hold_q;
    assign stall_d   = (sram_en && !mem_available && (stall_q != 32'hFFFF_FFFF))
                     ? stall_q + 32'd1 : stall_q;

    assign sram_rdata = rd_pend_q ? ram_rdata : hold_q;
    assign stall_cnt  = stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            lat_wen_q  <= '0;
            lat_addr_q <= '0;
            rd_pend_q  <= 1'b0;
            hold_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_wen_q  <= lat_wen_d;
            lat_addr_q <= lat_addr_d;
            rd_pend_q  <= rd_pend_d;
            hold_q     <= hold_d;
            stall_q    <= stall_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// tb_data_sram_responder : directed bench for data_sram_responder with
//                          WAIT_CYCLES=2 and WAIT_CYCLES=0 instances. Rev 1.0
// ============================================================================
module tb_data_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;

    logic        a_en, b_en;
    logic [3:0]  a_wen, b_wen;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_avail, b_avail;
    logic        a_ram_en, b_ram_en;
    logic [3:0]  a_ram_we, b_ram_we;
    logic [15:0] a_ram_addr, b_ram_addr;
    logic [31:0] a_ram_wdata, b_ram_wdata;
    logic [31:0] a_ram_rdata = 32'd0;
    logic [31:0] b_ram_rdata = 32'd0;
    logic [31:0] a_stall, b_stall;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    int total = 0;
    int bad   = 0;

    data_sram_responder #(.WAIT_CYCLES(2), .ADDR_W(16)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .sram_en(a_en), .sram_wen(a_wen), .sram_addr(a_addr), .sram_wdata(a_wdata),
        .sram_rdata(a_rdata), .mem_available(a_avail),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .stall_cnt(a_stall)
    );

    data_sram_responder #(.WAIT_CYCLES(0), .ADDR_W(16)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .sram_en(b_en), .sram_wen(b_wen), .sram_addr(b_addr), .sram_wdata(b_wdata),
        .sram_rdata(b_rdata), .mem_available(b_avail),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .stall_cnt(b_stall)
    );

    // Synchronous single-port RAM models with byte enables.
    always @(posedge clk) begin
        if (a_ram_en) begin
            for (int k = 0; k < 4; k++)
                if (a_ram_we[k]) mem_a[a_ram_addr[7:0]][8*k +: 8] <= a_ram_wdata[8*k +: 8];
            if (a_ram_we == 4'b0000) a_ram_rdata <= mem_a[a_ram_addr[7:0]];
        end
        if (b_ram_en) begin
            for (int k = 0; k < 4; k++)
                if (b_ram_we[k]) mem_b[b_ram_addr[7:0]][8*k +: 8] <= b_ram_wdata[8*k +: 8];
            if (b_ram_we == 4'b0000) b_ram_rdata <= mem_b[b_ram_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'hA000_0000 + i;
            mem_b[i] = 32'hB000_0000 + i;
        end
        mem_a[2] = 32'h0000_0000;

        resetn = 1'b0;
        a_en = 1'b1; a_wen = 4'h0; a_addr = 32'h1000_0010; a_wdata = 32'h0;
        b_en = 1'b1; b_wen = 4'h0; b_addr = 32'h0;         b_wdata = 32'h0;

        // Reset state with requests present
        repeat (2) @(posedge clk);
        #5;
        chk("rst_rdata",  a_rdata, 32'h0);
        chk("rst_avail",  {31'd0, a_avail}, 32'd1);
        chk("rst_ram_en", {31'd0, a_ram_en}, 32'd0);
        chk("rst_ram_we", {28'd0, a_ram_we}, 32'd0);
        chk("rst_stall",  a_stall, 32'd0);
        chk("rst_b_avail",  {31'd0, b_avail}, 32'd1);
        chk("rst_b_ram_en", {31'd0, b_ram_en}, 32'd0);

        // Read, two stall cycles, grant on third
        next_cycle(); resetn = 1'b1; b_en = 1'b0;
        #4; chk("rd_c1_avail", {31'd0, a_avail}, 32'd0);
            chk("rd_c1_ram_en", {31'd0, a_ram_en}, 32'd0);
        next_cycle();
        #4; chk("rd_c2_avail", {31'd0, a_avail}, 32'd0);
        next_cycle();
        #4; chk("rd_c3_avail", {31'd0, a_avail}, 32'd1);
            chk("rd_c3_ram_en", {31'd0, a_ram_en}, 32'd1);
            chk("rd_c3_ram_addr", {16'd0, a_ram_addr}, 32'h4);
            chk("rd_c3_ram_we", {28'd0, a_ram_we}, 32'd0);
        next_cycle(); a_en = 1'b0;
        #4; chk("rd_c4_rdata", a_rdata, 32'hA000_0004);
            chk("rd_c4_stall", a_stall, 32'd2);
        next_cycle();
        #4; chk("rd_c5_hold", a_rdata, 32'hA000_0004);

        // Byte-masked write then read-back
        next_cycle(); a_en = 1'b1; a_wen = 4'b0011; a_wdata = 32'h0000_BEEF; a_addr = 32'h8;
        #4; chk("wr_c1_avail", {31'd0, a_avail}, 32'd0);
            chk("wr_c1_ram_we", {28'd0, a_ram_we}, 32'd0);
        next_cycle();
        #4; chk("wr_c2_ram_we", {28'd0, a_ram_we}, 32'd0);
        next_cycle();
        #4; chk("wr_c3_ram_en", {31'd0, a_ram_en}, 32'd1);
            chk("wr_c3_ram_we", {28'd0, a_ram_we}, 32'b0011);
            chk("wr_c3_ram_addr", {16'd0, a_ram_addr}, 32'h2);
            chk("wr_c3_wdata", a_ram_wdata, 32'h0000_BEEF);
        next_cycle(); a_wen = 4'b0000; a_wdata = 32'h0;
        #4; chk("wr_keeps_rdata", a_rdata, 32'hA000_0004);
            chk("rb_c1_avail", {31'd0, a_avail}, 32'd0);
        next_cycle();
        #4; chk("rb_c2_avail", {31'd0, a_avail}, 32'd0);
        next_cycle();
        #4; chk("rb_c3_avail", {31'd0, a_avail}, 32'd1);
            chk("rb_c3_ram_addr", {16'd0, a_ram_addr}, 32'h2);
        next_cycle(); a_en = 1'b0;
        #4; chk("rb_rdata", a_rdata, 32'h0000_BEEF);
            chk("rb_stall", a_stall, 32'd6);

        // Abort after one wait cycle
        next_cycle(); a_en = 1'b1; a_addr = 32'h40;
        #4; chk("ab_c1_ram_en", {31'd0, a_ram_en}, 32'd0);
        next_cycle();
        #4; chk("ab_c2_ram_en", {31'd0, a_ram_en}, 32'd0);
        next_cycle(); a_en = 1'b0;
        #4; chk("ab_c3_ram_en", {31'd0, a_ram_en}, 32'd0);
            chk("ab_c3_avail", {31'd0, a_avail}, 32'd1);
        next_cycle();
        #4; chk("ab_c4_ram_en", {31'd0, a_ram_en}, 32'd0);
            chk("ab_rdata", a_rdata, 32'h0000_BEEF);
            chk("ab_stall", a_stall, 32'd8);

        // Address change in WAIT restarts the wait
        next_cycle(); a_en = 1'b1; a_addr = 32'h10;
        #4; chk("ac_c1_avail", {31'd0, a_avail}, 32'd0);
        next_cycle(); a_addr = 32'h20;
        #4; chk("ac_c2_avail", {31'd0, a_avail}, 32'd0);
        next_cycle();
        #4; chk("ac_c3_avail", {31'd0, a_avail}, 32'd0);
            chk("ac_c3_ram_en", {31'd0, a_ram_en}, 32'd0);
        next_cycle();
        #4; chk("ac_c4_avail", {31'd0, a_avail}, 32'd1);
            chk("ac_c4_ram_addr", {16'd0, a_ram_addr}, 32'h8);
        next_cycle(); a_en = 1'b0;
        #4; chk("ac_rdata", a_rdata, 32'hA000_0008);
            chk("ac_stall", a_stall, 32'd11);

        // Reset asserted mid-WAIT of a pending write
        next_cycle(); a_en = 1'b1; a_wen = 4'hF; a_wdata = 32'hDEAD_DEAD; a_addr = 32'hC;
        #4; chk("mr_c1_avail", {31'd0, a_avail}, 32'd0);
        next_cycle();
        #2; resetn = 1'b0;
        #2; chk("mr_rdata", a_rdata, 32'h0);
            chk("mr_ram_en", {31'd0, a_ram_en}, 32'd0);
            chk("mr_ram_we", {28'd0, a_ram_we}, 32'd0);
            chk("mr_avail", {31'd0, a_avail}, 32'd1);
            chk("mr_stall", a_stall, 32'd0);
        next_cycle();
        #4; chk("mr_c3_ram_en", {31'd0, a_ram_en}, 32'd0);
            chk("mr_mem_kept", mem_a[3], 32'hA000_0003);
        next_cycle(); resetn = 1'b1; a_wen = 4'h0; a_wdata = 32'h0; a_addr = 32'h1000_0010;
        #4; chk("pr_c1_avail", {31'd0, a_avail}, 32'd0);
        next_cycle();
        #4; chk("pr_c2_avail", {31'd0, a_avail}, 32'd0);
        next_cycle();
        #4; chk("pr_c3_avail", {31'd0, a_avail}, 32'd1);
            chk("pr_c3_ram_addr", {16'd0, a_ram_addr}, 32'h4);
        next_cycle(); a_en = 1'b0;
        #4; chk("pr_rdata", a_rdata, 32'hA000_0004);
            chk("pr_stall", a_stall, 32'd2);
            chk("pr_mem_kept", mem_a[3], 32'hA000_0003);

        // Zero-wait instance: back-to-back reads
        next_cycle(); b_en = 1'b1; b_wen = 4'h0; b_addr = 32'h0;
        #4; chk("zw_c1_avail", {31'd0, b_avail}, 32'd1);
            chk("zw_c1_ram_en", {31'd0, b_ram_en}, 32'd1);
            chk("zw_c1_ram_addr", {16'd0, b_ram_addr}, 32'h0);
        next_cycle(); b_addr = 32'h4;
        #4; chk("zw_c2_avail", {31'd0, b_avail}, 32'd1);
            chk("zw_c2_ram_addr", {16'd0, b_ram_addr}, 32'h1);
            chk("zw_c2_rdata", b_rdata, 32'hB000_0000);
        next_cycle(); b_en = 1'b0;
        #4; chk("zw_c3_rdata", b_rdata, 32'hB000_0001);
        next_cycle();
        #4; chk("zw_c4_hold", b_rdata, 32'hB000_0001);
            chk("zw_stall", b_stall, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
